coax_txrx_sequencer: RTL and testbench

Sequences one coax command/response transaction on the existing TX and RX datapaths. On a start request it flushes the receiver, kicks the transmitter, waits for transmission to finish, then times the device response window and waits for reception to end. Reports a single completion status. Sits between the SPI command controller, which requests transactions and reads status, and the coax TX/RX blocks, which it drives with strobes.

---
 rtl/coax_pkg.sv | 30 +++
 rtl/coax_timer.sv | 34 +++
 rtl/coax_txrx_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_coax_txrx_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coax_pkg.sv
// Shared definitions for the coax transaction sequencer: status codes,
// sequencer state encoding and default timeout values.
package coax_pkg;

  localparam logic [2:0] ST_OK         = 3'd0;
  localparam logic [2:0] ST_TX_EMPTY   = 3'd1;
  localparam logic [2:0] ST_TX_STALL   = 3'd2;
  localparam logic [2:0] ST_RX_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_RX_ERROR   = 3'd4;
  localparam logic [2:0] ST_RX_NO_DATA = 3'd5;
  localparam logic [2:0] ST_ABORTED    = 3'd6;

  localparam int DEF_TX_START_TIMEOUT = 64;
  localparam int DEF_RESPONSE_TIMEOUT = 228;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_START,
    S_TX_WAIT_ACTIVE,
    S_TX_WAIT_DONE,
    S_RX_WAIT_START,
    S_RX_WAIT_DONE,
    S_DONE
  } seq_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/coax_timer.sv
// Clearable, saturating up-counter with an equality compare against a
// caller-supplied limit.
module coax_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == limit);

endmodule

// File: rtl/coax_txrx_sequencer.sv
// Runs one coax command/response transaction: flush RX, kick TX, wait for
// TX to finish, time the response window, wait for RX, report a status.
module coax_txrx_sequencer
  import coax_pkg::*;
#(
  parameter int TX_START_TIMEOUT = DEF_TX_START_TIMEOUT,
  parameter int RESPONSE_TIMEOUT = DEF_RESPONSE_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_strobe,
  input  logic       expect_response,
  input  logic       abort_strobe,
  input  logic       tx_empty,
  input  logic       tx_active,
  output logic       tx_start_strobe,
  output logic       tx_reset,
  input  logic       rx_active,
  input  logic       rx_error,
  input  logic       rx_empty,
  output logic       rx_reset,
  output logic       busy,
  output logic       done_strobe,
  output logic [2:0] status
);

  localparam int CNT_W = $clog2(max2(TX_START_TIMEOUT, RESPONSE_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] TX_LIM = CNT_W'(TX_START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RX_LIM = CNT_W'(RESPONSE_TIMEOUT - 1);

  seq_state_e state_q, state_d;
  logic       exp_q, exp_d;
  logic [2:0] res_q, res_d;
  logic [2:0] status_q, status_d;
  logic       tx_start_q, tx_start_d;
  logic       tx_reset_q, tx_reset_d;
  logic       rx_reset_q, rx_reset_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tmr_clr, tmr_hit;
  logic [CNT_W-1:0] tmr_limit;

  assign tmr_limit = (state_q == S_RX_WAIT_START) ? RX_LIM : TX_LIM;

  coax_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .limit (tmr_limit),
    .hit   (tmr_hit)
  );

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    res_d      = res_q;
    status_d   = status_q;
    tx_start_d = 1'b0;
    tx_reset_d = 1'b0;
    rx_reset_d = 1'b0;
    done_d     = 1'b0;
    tmr_clr    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_strobe) begin
          exp_d = expect_response;
          if (tx_empty) begin
            res_d   = ST_TX_EMPTY;
            state_d = S_DONE;
          end else begin
            rx_reset_d = expect_response;
            state_d    = S_TX_START;
          end
        end
      end
      S_TX_START: begin
        tx_start_d = 1'b1;
        tmr_clr    = 1'b1;
        state_d    = S_TX_WAIT_ACTIVE;
      end
      S_TX_WAIT_ACTIVE: begin
        if (tx_active) begin
          state_d = S_TX_WAIT_DONE;
        end else if (tmr_hit) begin
          res_d   = ST_TX_STALL;
          state_d = S_DONE;
        end
      end
      S_TX_WAIT_DONE: begin
        // Holding the counter clear here starts the response window at zero.
        tmr_clr = 1'b1;
        if (!tx_active) begin
          if (!exp_q) begin
            res_d   = ST_OK;
            state_d = S_DONE;
          end else begin
            state_d = S_RX_WAIT_START;
          end
        end
      end
      S_RX_WAIT_START: begin
        if (rx_error) begin
          res_d   = ST_RX_ERROR;
          state_d = S_DONE;
        end else if (rx_active) begin
          state_d = S_RX_WAIT_DONE;
        end else if (tmr_hit) begin
          res_d   = ST_RX_TIMEOUT;
          state_d = S_DONE;
        end
      end
      S_RX_WAIT_DONE: begin
        if (rx_error) begin
          res_d   = ST_RX_ERROR;
          state_d = S_DONE;
        end else if (!rx_active) begin
          res_d   = rx_empty ? ST_RX_NO_DATA : ST_OK;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        status_d = res_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An abort in the DONE cycle rewrites the completion in flight rather
    // than producing a second done pulse.
    if (abort_strobe && (state_q != S_IDLE)) begin
      tx_reset_d = 1'b1;
      rx_reset_d = exp_q;
      tx_start_d = 1'b0;
      res_d      = ST_ABORTED;
      if (state_q == S_DONE) begin
        status_d = ST_ABORTED;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end else begin
        done_d   = 1'b0;
        state_d  = S_DONE;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      exp_q      <= 1'b0;
      res_q      <= ST_OK;
      status_q   <= ST_OK;
      tx_start_q <= 1'b0;
      tx_reset_q <= 1'b0;
      rx_reset_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      res_q      <= res_d;
      status_q   <= status_d;
      tx_start_q <= tx_start_d;
      tx_reset_q <= tx_reset_d;
      rx_reset_q <= rx_reset_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_start_strobe = tx_start_q;
  assign tx_reset        = tx_reset_q;
  assign rx_reset        = rx_reset_q;
  assign busy            = busy_q;
  assign done_strobe     = done_q;
  assign status          = status_q;

endmodule

// File: tb/tb_coax_txrx_sequencer.sv
// Scenario bench for coax_txrx_sequencer; expected completion time and
// status come from an arithmetic model of the transaction timeline.
module tb_coax_txrx_sequencer;

  localparam int TXT    = 64;
  localparam int RT     = 228;
  localparam int BUDGET = 900;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_strobe = 1'b0, expect_response = 1'b0, abort_strobe = 1'b0;
  logic       tx_empty = 1'b0, tx_active = 1'b0;
  logic       rx_active = 1'b0, rx_error = 1'b0, rx_empty = 1'b0;
  logic       tx_start_strobe, tx_reset, rx_reset, busy, done_strobe;
  logic [2:0] status;

  coax_txrx_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start_strobe    (start_strobe),
    .expect_response (expect_response),
    .abort_strobe    (abort_strobe),
    .tx_empty        (tx_empty),
    .tx_active       (tx_active),
    .tx_start_strobe (tx_start_strobe),
    .tx_reset        (tx_reset),
    .rx_active       (rx_active),
    .rx_error        (rx_error),
    .rx_empty        (rx_empty),
    .rx_reset        (rx_reset),
    .busy            (busy),
    .done_strobe     (done_strobe),
    .status          (status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scenario: start at cycle 0; tx_active high for L cycles starting at 2+a;
  // rx_active rises d cycles after tx_active falls and holds R cycles.
  int sc_exp, sc_txe, sc_a, sc_L, sc_d, sc_R, sc_rxe, sc_err, sc_abort, sc_extra, sc_rst;
  int ob_done_cnt, ob_done_t, ob_txs_cnt, ob_txs_t, ob_rxr_cnt, ob_rxr_t;
  int ob_txr_cnt, ob_txr_t, ob_busy1, ob_busy_done, ob_rst_zero;
  logic [2:0] ob_status;
  int m_done, m_status;

  task automatic set_default();
    sc_exp = 0; sc_txe = 0; sc_a = 3; sc_L = 10; sc_d = 1000; sc_R = 10;
    sc_rxe = 0; sc_err = -1; sc_abort = -1; sc_extra = -1; sc_rst = -1;
  endtask

  task automatic model();
    int f;
    f = 2 + sc_a + sc_L;
    if (sc_txe != 0)        begin m_done = 2;                        m_status = 1; end
    else if (sc_a >= TXT)   begin m_done = TXT + 3;                  m_status = 2; end
    else if (sc_exp == 0)   begin m_done = f + 2;                    m_status = 0; end
    else if (sc_d > RT)     begin m_done = f + RT + 2;               m_status = 3; end
    else if (sc_err >= 0)   begin m_done = f + sc_d + sc_err + 2;    m_status = 4; end
    else                    begin m_done = f + sc_d + sc_R + 2;      m_status = (sc_rxe != 0) ? 5 : 0; end
    if (sc_abort >= 1 && sc_abort < m_done) begin
      if (sc_abort != m_done - 1) m_done = sc_abort + 2;
      m_status = 6;
    end
  endtask

  task automatic run_txn();
    int f, stop;
    f = 2 + sc_a + sc_L;
    ob_done_cnt = 0; ob_done_t = -1; ob_txs_cnt = 0; ob_txs_t = -1; ob_rxr_cnt = 0; ob_rxr_t = -1;
    ob_txr_cnt = 0; ob_txr_t = -1; ob_busy1 = -1; ob_busy_done = -1; ob_rst_zero = -1; ob_status = 3'bx;
    stop = BUDGET;
    for (int t = 0; t < stop; t++) begin
      if (done_strobe) begin
        ob_done_cnt++;
        if (ob_done_t < 0) begin
          ob_done_t = t; ob_status = status; ob_busy_done = int'(busy); stop = t + 4;
        end
      end
      if (tx_start_strobe) begin ob_txs_cnt++; if (ob_txs_t < 0) ob_txs_t = t; end
      if (rx_reset) begin ob_rxr_cnt++; ob_rxr_t = t; end
      if (tx_reset) begin ob_txr_cnt++; ob_txr_t = t; end
      if (t == 1) ob_busy1 = int'(busy);
      if (sc_rst >= 0 && t == sc_rst + 1) begin
        ob_rst_zero = ({tx_start_strobe, tx_reset, rx_reset, busy, done_strobe, status} == 8'd0) ? 1 : 0;
        stop = t + 4;
      end
      start_strobe    = (t == 0) || (t == sc_extra);
      expect_response = (t == 0) ? sc_exp[0] : 1'($urandom_range(0, 1));
      tx_empty        = (t == 0) ? sc_txe[0] : 1'($urandom_range(0, 1));
      tx_active       = (t >= 2 + sc_a) && (t < f);
      rx_active       = (t >= f + sc_d) && (t < f + sc_d + sc_R);
      rx_error        = (sc_err >= 0) && (t == f + sc_d + sc_err);
      rx_empty        = sc_rxe[0];
      abort_strobe    = (t == sc_abort);
      reset           = (t == sc_rst);
      @(posedge clk); #1;
    end
    start_strobe = 0; expect_response = 0; tx_empty = 0; tx_active = 0;
    rx_active = 0; rx_error = 0; abort_strobe = 0; reset = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start_strobe = 1; tx_empty = 0; expect_response = 1; abort_strobe = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_start_strobe !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start_strobe); end
    checks++; if (tx_reset !== 1'b0)        begin errors++; $display("FAIL reset_tx_reset got %b want 0", tx_reset); end
    checks++; if (rx_reset !== 1'b0)        begin errors++; $display("FAIL reset_rx_reset got %b want 0", rx_reset); end
    checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done_strobe !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done_strobe); end
    checks++; if (status !== 3'd0)          begin errors++; $display("FAIL reset_status got %0d want 0", status); end
    start_strobe = 0; abort_strobe = 0; expect_response = 0;
    reset = 0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
  endtask

  task automatic test_tx_only();
    set_default(); sc_a = $urandom_range(1, 10); sc_L = 40;
    model(); run_txn();
    checks++; if (ob_done_t !== m_done)    begin errors++; $display("FAIL txonly_done_t got %0d want %0d", ob_done_t, m_done); end
    checks++; if (ob_status !== 3'(m_status)) begin errors++; $display("FAIL txonly_status got %0d want %0d", ob_status, m_status); end
    checks++; if (ob_txs_t !== 2)          begin errors++; $display("FAIL txonly_txstart_t got %0d want 2", ob_txs_t); end
    checks++; if (ob_txs_cnt !== 1)        begin errors++; $display("FAIL txonly_txstart_cnt got %0d want 1", ob_txs_cnt); end
    checks++; if (ob_rxr_cnt !== 0)        begin errors++; $display("FAIL txonly_rxreset_cnt got %0d want 0", ob_rxr_cnt); end
    checks++; if (ob_busy1 !== 1)          begin errors++; $display("FAIL txonly_busy1 got %0d want 1", ob_busy1); end
    checks++; if (ob_busy_done !== 0)      begin errors++; $display("FAIL txonly_busy_after got %0d want 0", ob_busy_done); end
    checks++; if (ob_done_cnt !== 1)       begin errors++; $display("FAIL txonly_done_cnt got %0d want 1", ob_done_cnt); end
  endtask

  task automatic test_response();
    set_default(); sc_exp = 1; sc_a = $urandom_range(1, 10); sc_L = 20; sc_d = 100; sc_R = 30;
    model(); run_txn();
    checks++; if (ob_rxr_t !== 1)          begin errors++; $display("FAIL resp_rxreset_t got %0d want 1", ob_rxr_t); end
    checks++; if (ob_rxr_cnt !== 1)        begin errors++; $display("FAIL resp_rxreset_cnt got %0d want 1", ob_rxr_cnt); end
    checks++; if (ob_done_t !== m_done)    begin errors++; $display("FAIL resp_done_t got %0d want %0d", ob_done_t, m_done); end
    checks++; if (ob_status !== 3'(m_status)) begin errors++; $display("FAIL resp_status got %0d want %0d", ob_status, m_status); end
    sc_rxe = 1; model(); run_txn();
    checks++; if (ob_status !== 3'(m_status)) begin errors++; $display("FAIL resp_nodata_status got %0d want %0d", ob_status, m_status); end
  endtask

  task automatic test_timeout();
    int dl [3] = '{1000, RT, RT + 1};
    for (int i = 0; i < 3; i++) begin
      set_default(); sc_exp = 1; sc_d = dl[i]; sc_R = 5;
      model(); run_txn();
      checks++; if (ob_done_t !== m_done)    begin errors++; $display("FAIL timeout_done_t d=%0d got %0d want %0d", sc_d, ob_done_t, m_done); end
      checks++; if (ob_status !== 3'(m_status)) begin errors++; $display("FAIL timeout_status d=%0d got %0d want %0d", sc_d, ob_status, m_status); end
    end
  endtask

  task automatic test_errors();
    set_default(); sc_exp = 1; sc_d = 50; sc_R = 30; sc_err = 15;
    model(); run_txn();
    checks++; if (ob_status !== 3'd4)      begin errors++; $display("FAIL rxerr_status got %0d want 4", ob_status); end
    checks++; if (ob_done_t !== m_done)    begin errors++; $display("FAIL rxerr_done_t got %0d want %0d", ob_done_t, m_done); end
    set_default(); sc_txe = 1;
    model(); run_txn();
    checks++; if (ob_status !== 3'd1)      begin errors++; $display("FAIL txempty_status got %0d want 1", ob_status); end
    checks++; if (ob_done_t !== 2)         begin errors++; $display("FAIL txempty_done_t got %0d want 2", ob_done_t); end
    checks++; if (ob_txs_cnt !== 0)        begin errors++; $display("FAIL txempty_txstart_cnt got %0d want 0", ob_txs_cnt); end
    set_default(); sc_a = 1000;
    model(); run_txn();
    checks++; if (ob_status !== 3'd2)      begin errors++; $display("FAIL stall_status got %0d want 2", ob_status); end
    checks++; if (ob_done_t !== m_done)    begin errors++; $display("FAIL stall_done_t got %0d want %0d", ob_done_t, m_done); end
  endtask

  task automatic test_abort();
    int a_t;
    set_default(); sc_exp = 1;
    a_t = 2 + sc_a + sc_L + $urandom_range(1, RT);
    sc_abort = a_t;
    model(); run_txn();
    checks++; if (ob_txr_t !== a_t + 1)    begin errors++; $display("FAIL abort_txreset_t got %0d want %0d", ob_txr_t, a_t + 1); end
    checks++; if (ob_txr_cnt !== 1)        begin errors++; $display("FAIL abort_txreset_cnt got %0d want 1", ob_txr_cnt); end
    checks++; if (ob_rxr_cnt !== 2)        begin errors++; $display("FAIL abort_rxreset_cnt got %0d want 2", ob_rxr_cnt); end
    checks++; if (ob_rxr_t !== a_t + 1)    begin errors++; $display("FAIL abort_rxreset_t got %0d want %0d", ob_rxr_t, a_t + 1); end
    checks++; if (ob_status !== 3'd6)      begin errors++; $display("FAIL abort_status got %0d want 6", ob_status); end
    checks++; if (ob_done_t !== a_t + 2)   begin errors++; $display("FAIL abort_done_t got %0d want %0d", ob_done_t, a_t + 2); end
  endtask

  task automatic test_busy_start();
    set_default(); sc_L = 40; sc_extra = 10;
    model(); run_txn();
    checks++; if (ob_done_cnt !== 1)       begin errors++; $display("FAIL busystart_done_cnt got %0d want 1", ob_done_cnt); end
    checks++; if (ob_txs_cnt !== 1)        begin errors++; $display("FAIL busystart_txstart_cnt got %0d want 1", ob_txs_cnt); end
    checks++; if (ob_done_t !== m_done)    begin errors++; $display("FAIL busystart_done_t got %0d want %0d", ob_done_t, m_done); end
  endtask

  task automatic test_reset_mid();
    set_default(); sc_a = 2; sc_L = 40; sc_rst = 14;
    run_txn();
    checks++; if (ob_rst_zero !== 1)       begin errors++; $display("FAIL midreset_outputs got %0d want 1", ob_rst_zero); end
    checks++; if (ob_done_cnt !== 0)       begin errors++; $display("FAIL midreset_done_cnt got %0d want 0", ob_done_cnt); end
    set_default(); sc_L = 25;
    model(); run_txn();
    checks++; if (ob_done_t !== m_done)    begin errors++; $display("FAIL fresh_done_t got %0d want %0d", ob_done_t, m_done); end
    checks++; if (ob_status !== 3'(m_status)) begin errors++; $display("FAIL fresh_status got %0d want %0d", ob_status, m_status); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      set_default();
      sc_exp = $urandom_range(0, 1);
      sc_txe = ($urandom_range(0, 7) == 0) ? 1 : 0;
      sc_a   = ($urandom_range(0, 5) == 0) ? $urandom_range(TXT, TXT + 6) : $urandom_range(0, 20);
      sc_L   = $urandom_range(1, 50);
      sc_d   = $urandom_range(1, 240);
      sc_R   = $urandom_range(1, 40);
      sc_rxe = $urandom_range(0, 1);
      if (sc_exp == 1 && sc_d <= RT && sc_R >= 2 && $urandom_range(0, 3) == 0)
        sc_err = $urandom_range(1, sc_R - 1);
      model();
      if (m_done > 2 && $urandom_range(0, 5) == 0) sc_abort = $urandom_range(1, m_done - 1);
      model();
      if (m_done > 2 && $urandom_range(0, 3) == 0) sc_extra = $urandom_range(1, m_done - 1);
      run_txn();
      checks++; if (ob_done_t !== m_done)    begin errors++; $display("FAIL rand%0d_done_t got %0d want %0d", i, ob_done_t, m_done); end
      checks++; if (ob_status !== 3'(m_status)) begin errors++; $display("FAIL rand%0d_status got %0d want %0d", i, ob_status, m_status); end
      checks++; if (ob_done_cnt !== 1)       begin errors++; $display("FAIL rand%0d_done_cnt got %0d want 1", i, ob_done_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_tx_only();
    test_response();
    test_timeout();
    test_errors();
    test_abort();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
